line_drawer: RTL

Bresenham line rasterizer that converts one endpoint pair into a stream of pixel writes, one pixel per clock. It sits directly upstream of VGA_framebuffer. line_animator, or any later scene logic, issues a start with endpoints and a colour. line_drawer then drives the framebuffer x/y/pixel_color/pixel_write inputs until the line is complete. It handles all eight octants, so endpoints may be given in any order.

---
 rtl/line_drawer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/line_drawer.sv
// Bresenham line rasterizer: turns one endpoint pair into one framebuffer pixel write per clock.
// All eight octants are covered by latching per-axis step directions at INIT.
module line_drawer #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic             color_in,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             pixel_color,
  output logic             pixel_write,
  output logic             busy,
  output logic             done
);

  localparam int EW = WIDTH + 2;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [WIDTH-1:0]       x_q, x_d, y_q, y_d;
  logic                   color_q, color_d;
  logic                   sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic signed [EW-1:0]   dx_q, dx_d, dy_q, dy_d, err_q, err_d;

  logic signed [EW-1:0]   xdiff, ydiff;
  logic signed [EW:0]     e2, dx_ext, dy_ext;
  logic                   step_x, step_y, at_end;

  assign xdiff  = $signed({2'b00, x1_q}) - $signed({2'b00, x0_q});
  assign ydiff  = $signed({2'b00, y1_q}) - $signed({2'b00, y0_q});
  assign e2     = $signed({err_q, 1'b0});
  assign dx_ext = $signed({dx_q[EW-1], dx_q});
  assign dy_ext = $signed({dy_q[EW-1], dy_q});
  assign step_x = (e2 >= dy_ext);
  assign step_y = (e2 <= dx_ext);
  assign at_end = (x_q == x1_q) && (y_q == y1_q);

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    x_d      = x_q;
    y_d      = y_q;
    color_d  = color_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x0_d    = x0;
          y0_d    = y0;
          x1_d    = x1;
          y1_d    = y1;
          color_d = color_in;
          state_d = INIT;
        end
      end
      INIT: begin
        // dy is kept negative so a single err register serves both axes
        dx_d     = xdiff[EW-1] ? -xdiff : xdiff;
        dy_d     = ydiff[EW-1] ? ydiff : -ydiff;
        sx_neg_d = !(x0_q < x1_q);
        sy_neg_d = !(y0_q < y1_q);
        err_d    = dx_d + dy_d;
        x_d      = x0_q;
        y_d      = y0_q;
        state_d  = DRAW;
      end
      DRAW: begin
        if (at_end) begin
          state_d = DONE;
        end else begin
          err_d = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
          if (step_x) x_d = sx_neg_q ? (x_q - ONE) : (x_q + ONE);
          if (step_y) y_d = sy_neg_q ? (y_q - ONE) : (y_q + ONE);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      color_q  <= 1'b0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      x_q      <= x_d;
      y_q      <= y_d;
      color_q  <= color_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign pixel_color = color_q;
  assign pixel_write = (state_q == DRAW);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule
